reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Parametrised RAW-hazard scoreboard and forwarding-select generator for the 5-stage in-order pipeline.
- Sits beside the ID stage. Tracks in-flight destination registers across the stages after ID (EX, ME, WB by default).
- Per ID read port, it reports where the operand must come from (register file or a pipeline stage), or that ID must stall.
- Honours the global single-step enable `step` and a branch flush of the ID instruction.

Parameters:
- REG_BITS, 5: register-index width (32 registers).
- DEPTH, 3: tracked stages after ID. Slot 0 = EX, slot DEPTH-1 = WB.
- NRD, 2: number of ID read ports (rs, rt).
- LOAD_READY, 2: lowest slot index at which load data is forwardable. Must be less than DEPTH.
- SELW (localparam): clog2(DEPTH+1), the width of one forward-select field.

Ports:
- clk  in  1  clock, rising edge.
- aresetn  in  1  reset, synchronous, active-low.
- step  in  1  pipeline advance enable. When 0, all state holds.
- flush  in  1  kill the instruction currently in ID (taken branch); it enters slot 0 as a bubble.
- id_valid  in  1  ID holds a real instruction.
- id_we  in  1  ID instruction writes the register file.
- id_load  in  1  ID instruction is a load (result available only at slot ≥ LOAD_READY).
- id_wd  in  REG_BITS  ID destination register.
- rd_req  in  NRD  per-port "operand required".
- rd_addr  in  NRD*REG_BITS  per-port source register; port p is at bits [p*REG_BITS +: REG_BITS].
- stall  out  1  ID must hold this cycle (combinational).
- fwd_sel  out  NRD*SELW  per-port source select (combinational). 0 = register file; k+1 = forward from slot k.
- pending_cnt  out  clog2(DEPTH+1)  number of valid writing slots (registered-state derived).

Behaviour:
- State: DEPTH slots, each holding {v, we, load, wd}.
- Reset (aresetn=0 at a clk edge):
  - all slots cleared to zero;
  - consequently stall=0, every fwd_sel=0, pending_cnt=0.
  - Reset overrides step and flush. Reset mid-stream discards all in-flight entries; no hazard survives reset.
- A slot "matches" port p when all of the following hold:
  - v=1, we=1, wd≠0;
  - wd = rd_addr[p];
  - rd_req[p]=1.
- Port resolution (combinational):
  - Pick the lowest-index (youngest) matching slot k. Older matches are ignored.
  - No match: fwd_sel[p]=0, no stall from port p.
  - Match with load=1 and k<LOAD_READY: port p requests a stall; fwd_sel[p]=0.
  - Otherwise: fwd_sel[p]=k+1.
- stall = OR of the port stall requests, gated by id_valid. A stall is never raised for a bubble in ID.
- Register 0 never creates a hazard. rd_addr=0 always yields fwd_sel=0.
- Advance (clk edge with aresetn=1 and step=1):
  - slot[k] ← slot[k-1] for k ≥ 1. The WB slot entry retires.
  - slot[0] ← {id_valid, id_we, id_load, id_wd} when stall=0 and flush=0.
  - slot[0] ← bubble (all zero) when stall=1 or flush=1.
  - Older slots always advance during a stall (bubble insertion), so a load-use stall lasts exactly LOAD_READY minus the load's slot index cycles.
- step=0: all slots hold. Outputs stay consistent with the held state. The stall output may still be 1.
- stall and flush together: bubble is inserted (flush wins semantically; result identical).
- pending_cnt = count of slots with v&we&(wd≠0). Range 0..DEPTH, no wrap.
- Latency:
  - Hazard and forward outputs reflect the current slots with zero latency.
  - An issued instruction is visible in slot 0 one advancing edge later.

Test Plan:
- Reset: hold aresetn=0 for 2 cycles with id_valid=1, id_wd=5 → stall=0, fwd_sel=0, pending_cnt=0. First edge after release still shows empty slots.
- ALU RAW: issue wd=3 (non-load). Next cycle rd_addr[0]=3 → fwd_sel[0]=1, stall=0. One cycle later (nothing new issued) → fwd_sel[0]=2. Then 3. Then 0 after it retires.
- Load-use: issue load wd=8. Next cycle port1 reads 8 → stall=1 for 2 step cycles, bubbles enter slot 0. Third cycle fwd_sel[1]=3, stall=0.
- Youngest wins: issue wd=4, then wd=4 again. Read 4 → fwd_sel=1 (not 2). Also read r0 with a slot wd=0 we=1 → fwd_sel=0, pending_cnt excludes it.
- step gating: load wd=9 in slot 0, dependent read in ID, step=0 for 5 cycles → slots and stall=1 frozen. step=1 resumes with 2 stall cycles total.
- Flush: flush=1 with id_valid=1, id_wd=7 → next cycle slot 0 empty, read of 7 gives fwd_sel=0, pending_cnt unchanged.

Source files
------------

// File: rtl/reg_scoreboard.sv
// RAW-hazard scoreboard for the in-order pipeline: tracks in-flight destination
// registers after ID and produces per-read-port forward selects and the ID stall.
module reg_scoreboard #(
   parameter int  REG_BITS   = 5,
   parameter int  DEPTH      = 3,
   parameter int  NRD        = 2,
   parameter int  LOAD_READY = 2,
   localparam int SELW       = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    aresetn,
   input  logic                    step,
   input  logic                    flush,
   input  logic                    id_valid,
   input  logic                    id_we,
   input  logic                    id_load,
   input  logic [REG_BITS-1:0]     id_wd,
   input  logic [NRD-1:0]          rd_req,
   input  logic [NRD*REG_BITS-1:0] rd_addr,
   output logic                    stall,
   output logic [NRD*SELW-1:0]     fwd_sel,
   output logic [SELW-1:0]         pending_cnt
);

   typedef struct packed {
      logic                v;
      logic                we;
      logic                load;
      logic [REG_BITS-1:0] wd;
   } slot_t;

   slot_t            slot_reg [DEPTH];
   slot_t            issue_next;
   logic [DEPTH-1:0] live;
   logic [NRD-1:0]   port_stall;

   genvar gi, gj;

   // A slot can only ever produce a hazard if it really writes a non-zero register.
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_live
         assign live[gi] = slot_reg[gi].v & slot_reg[gi].we & (slot_reg[gi].wd != '0);
      end
   endgenerate

   always_comb begin
      pending_cnt = '0;
      for (int k = 0; k < DEPTH; k++) begin
         pending_cnt = pending_cnt + SELW'(live[k]);
      end
   end

   generate
      for (gi = 0; gi < NRD; gi++) begin : g_port
         logic [REG_BITS-1:0] addr;
         logic [DEPTH-1:0]    hit;
         logic [SELW-1:0]     sel;
         logic                req_stall;

         assign addr = rd_addr[gi*REG_BITS +: REG_BITS];

         for (gj = 0; gj < DEPTH; gj++) begin : g_hit
            assign hit[gj] = live[gj] & rd_req[gi] & (slot_reg[gj].wd == addr);
         end

         // Scan oldest to youngest so the youngest matching slot has the final say.
         always_comb begin
            sel       = '0;
            req_stall = 1'b0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
               if (hit[k]) begin
                  if (slot_reg[k].load && (k < LOAD_READY)) begin
                     sel       = '0;
                     req_stall = 1'b1;
                  end else begin
                     sel       = SELW'(k + 1);
                     req_stall = 1'b0;
                  end
               end
            end
         end

         assign fwd_sel[gi*SELW +: SELW] = sel;
         assign port_stall[gi]           = req_stall;
      end
   endgenerate

   assign stall      = id_valid & (|port_stall);
   assign issue_next = (stall || flush) ? '0 : {id_valid, id_we, id_load, id_wd};

   // Older slots keep draining while ID is held, which is what bounds a load-use stall.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         for (int k = 0; k < DEPTH; k++) begin
            slot_reg[k] <= '0;
         end
      end else if (step) begin
         slot_reg[0] <= issue_next;
         for (int k = 1; k < DEPTH; k++) begin
            slot_reg[k] <= slot_reg[k-1];
         end
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a cycle-by-cycle vector table followed by
// hand-written step-gating and mid-stream reset sequences.
module tb_reg_scoreboard;

   logic       clk;
   logic       aresetn;
   logic       step;
   logic       flush;
   logic       id_valid;
   logic       id_we;
   logic       id_load;
   logic [4:0] id_wd;
   logic [1:0] rd_req;
   logic [9:0] rd_addr;
   logic       stall;
   logic [3:0] fwd_sel;
   logic [1:0] pending_cnt;

   int n_total = 0;
   int n_pass  = 0;

   reg_scoreboard dut (
      .clk         (clk),
      .aresetn     (aresetn),
      .step        (step),
      .flush       (flush),
      .id_valid    (id_valid),
      .id_we       (id_we),
      .id_load     (id_load),
      .id_wd       (id_wd),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .stall       (stall),
      .fwd_sel     (fwd_sel),
      .pending_cnt (pending_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int rst_n, stp, fl, valid, we, load, wd, req, a0, a1;
      int e_stall, e_sel0, e_sel1, e_cnt;
   } vec_t;

   localparam int NV = 31;
   vec_t vecs [NV];

   function automatic vec_t mk(int rst_n, int stp, int fl, int valid, int we, int load,
                               int wd, int req, int a0, int a1,
                               int e_stall, int e_sel0, int e_sel1, int e_cnt);
      vec_t r;
      r.rst_n = rst_n; r.stp = stp; r.fl = fl; r.valid = valid; r.we = we;
      r.load = load; r.wd = wd; r.req = req; r.a0 = a0; r.a1 = a1;
      r.e_stall = e_stall; r.e_sel0 = e_sel0; r.e_sel1 = e_sel1; r.e_cnt = e_cnt;
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic check_outputs(input string tag, input int e_stall, input int e_sel0,
                                input int e_sel1, input int e_cnt);
      chk({tag, " stall"}, int'(stall), e_stall);
      chk({tag, " fwd_sel0"}, int'(fwd_sel[1:0]), e_sel0);
      chk({tag, " fwd_sel1"}, int'(fwd_sel[3:2]), e_sel1);
      chk({tag, " pending_cnt"}, int'(pending_cnt), e_cnt);
      $display("%s: stall=%0d sel0=%0d sel1=%0d cnt=%0d", tag, stall, fwd_sel[1:0],
               fwd_sel[3:2], pending_cnt);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_stall;

      //            rst stp fl  v we ld wd req a0 a1   stall s0 s1 cnt
      vecs[0]  = mk(0, 1, 0, 1, 1, 0, 5, 3, 5, 5,     0, 0, 0, 0);
      vecs[1]  = mk(0, 1, 0, 1, 1, 0, 5, 3, 5, 5,     0, 0, 0, 0);
      vecs[2]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0);
      vecs[3]  = mk(1, 1, 0, 1, 1, 0, 3, 0, 0, 0,     0, 0, 0, 0);
      vecs[4]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 3, 0,     0, 1, 0, 1);
      vecs[5]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 3, 0,     0, 2, 0, 1);
      vecs[6]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 3, 0,     0, 3, 0, 1);
      vecs[7]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 3, 0,     0, 0, 0, 0);
      vecs[8]  = mk(1, 1, 0, 1, 1, 1, 8, 0, 0, 0,     0, 0, 0, 0);
      vecs[9]  = mk(1, 1, 0, 1, 1, 0, 10, 2, 0, 8,    1, 0, 0, 1);
      vecs[10] = mk(1, 1, 0, 1, 1, 0, 10, 2, 0, 8,    1, 0, 0, 1);
      vecs[11] = mk(1, 1, 0, 1, 1, 0, 10, 2, 0, 8,    0, 0, 3, 1);
      vecs[12] = mk(1, 1, 0, 0, 0, 0, 0, 3, 10, 8,    0, 1, 0, 1);
      vecs[13] = mk(1, 1, 0, 1, 1, 0, 4, 0, 0, 0,     0, 0, 0, 1);
      vecs[14] = mk(1, 1, 0, 1, 1, 0, 4, 0, 0, 0,     0, 0, 0, 2);
      vecs[15] = mk(1, 1, 0, 1, 1, 0, 0, 3, 4, 4,     0, 1, 1, 2);
      vecs[16] = mk(1, 1, 0, 0, 0, 0, 0, 3, 0, 4,     0, 0, 2, 2);
      vecs[17] = mk(1, 1, 0, 0, 0, 0, 0, 3, 4, 0,     0, 3, 0, 1);
      vecs[18] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0);
      vecs[19] = mk(1, 1, 0, 1, 1, 0, 6, 0, 0, 0,     0, 0, 0, 0);
      vecs[20] = mk(1, 1, 0, 0, 0, 0, 0, 0, 6, 6,     0, 0, 0, 1);
      vecs[21] = mk(1, 1, 0, 1, 0, 0, 11, 0, 0, 0,    0, 0, 0, 1);
      vecs[22] = mk(1, 1, 0, 0, 0, 0, 0, 3, 11, 6,    0, 0, 3, 1);
      vecs[23] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0);
      vecs[24] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0);
      vecs[25] = mk(1, 1, 1, 1, 1, 0, 7, 0, 0, 0,     0, 0, 0, 0);
      vecs[26] = mk(1, 1, 0, 0, 0, 0, 0, 1, 7, 0,     0, 0, 0, 0);
      vecs[27] = mk(1, 1, 0, 1, 1, 1, 9, 0, 0, 0,     0, 0, 0, 0);
      vecs[28] = mk(1, 1, 0, 0, 0, 0, 0, 1, 9, 0,     0, 0, 0, 1);
      vecs[29] = mk(1, 1, 1, 1, 1, 0, 13, 1, 9, 0,    1, 0, 0, 1);
      vecs[30] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 1);

      aresetn = 1'b0; step = 1'b1; flush = 1'b0; id_valid = 1'b0; id_we = 1'b0;
      id_load = 1'b0; id_wd = '0; rd_req = '0; rd_addr = '0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         aresetn  = (vecs[i].rst_n != 0);
         step     = (vecs[i].stp != 0);
         flush    = (vecs[i].fl != 0);
         id_valid = (vecs[i].valid != 0);
         id_we    = (vecs[i].we != 0);
         id_load  = (vecs[i].load != 0);
         id_wd    = 5'(vecs[i].wd);
         rd_req   = 2'(vecs[i].req);
         rd_addr  = {5'(vecs[i].a1), 5'(vecs[i].a0)};
         #1;
         check_outputs($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_sel0,
                       vecs[i].e_sel1, vecs[i].e_cnt);
      end

      // Load-use hazard frozen by step=0, then released.
      @(negedge clk);
      step = 1'b1; flush = 1'b0; aresetn = 1'b1;
      id_valid = 1'b1; id_we = 1'b1; id_load = 1'b1; id_wd = 5'd9; rd_req = 2'b00; rd_addr = '0;
      @(negedge clk);
      id_load = 1'b0; id_wd = 5'd12; rd_req = 2'b01; rd_addr = {5'd0, 5'd9}; step = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         chk($sformatf("frozen%0d stall", i), int'(stall), 1);
         chk($sformatf("frozen%0d pending_cnt", i), int'(pending_cnt), 1);
         $display("frozen%0d: stall=%0d cnt=%0d", i, stall, pending_cnt);
      end
      @(negedge clk);
      step = 1'b1;
      n_stall = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (stall !== 1'b1) break;
         n_stall++;
         @(negedge clk);
      end
      chk("resume stall cycles", n_stall, 2);
      chk("resume fwd_sel0", int'(fwd_sel[1:0]), 3);
      $display("resume: stall_cycles=%0d sel0=%0d", n_stall, fwd_sel[1:0]);

      // Reset while entries are in flight, with step low: everything must clear.
      @(negedge clk);
      aresetn = 1'b0; step = 1'b0; id_valid = 1'b1; id_we = 1'b1; id_wd = 5'd13; rd_req = 2'b00;
      @(negedge clk);
      aresetn = 1'b1; step = 1'b1; id_valid = 1'b0; id_we = 1'b0;
      rd_req = 2'b11; rd_addr = {5'd13, 5'd12};
      #1;
      check_outputs("midreset", 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
